// File: rtl/input_event_pkg.sv
// Shared register offsets, event bit indices and input counts for the
// switch/button event controller.
package input_event_pkg;

  localparam int unsigned NUM_SW     = 16;
  localparam int unsigned NUM_BTN    = 4;
  localparam int unsigned NUM_IN     = NUM_SW + NUM_BTN;
  localparam int unsigned NUM_EVENTS = 5;

  localparam logic [31:0] OFF_SWITCHES = 32'h0000_0000;
  localparam logic [31:0] OFF_BUTTONS  = 32'h0000_0004;
  localparam logic [31:0] OFF_EVENTS   = 32'h0000_0008;
  localparam logic [31:0] OFF_IRQ_EN   = 32'h0000_000C;

  localparam int unsigned EV_BTN0 = 0;
  localparam int unsigned EV_BTN1 = 1;
  localparam int unsigned EV_BTN2 = 2;
  localparam int unsigned EV_BTN3 = 3;
  localparam int unsigned EV_SW   = 4;

endpackage

// File: rtl/input_event_ctrl_debounce.sv
// Single-input two-flop synchronizer followed by a stability counter that
// only accepts a new level after DEBOUNCE_CYCLES consecutive differing cycles.
module debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable
);

  // A one-cycle debounce still needs a 1-bit counter to stay legal
  localparam int unsigned CW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/input_event_ctrl.sv
// Memory-mapped switch/button controller: debounced levels, sticky W1C
// event flags, interrupt enable and a registered read port.
module input_event_ctrl
  import input_event_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic [15:0] switches,
  input  logic [3:0]  buttons,
  output logic [31:0] data_out,
  output logic        irq
);

  logic [NUM_IN-1:0]     raw;
  logic [NUM_IN-1:0]     stable;
  logic [NUM_IN-1:0]     stable_q;
  logic [NUM_EVENTS-1:0] events;
  logic [NUM_EVENTS-1:0] irq_en;
  logic [NUM_EVENTS-1:0] ev_set;
  logic [NUM_EVENTS-1:0] ev_clr;
  logic [31:0]           rdata;
  logic                  wr_events;
  logic                  wr_irq_en;
  logic                  unused_wdata;

  // Buttons occupy the low bits, switches the high bits
  assign raw = {switches, buttons};

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw[gi]),
      .stable(stable[gi])
    );
  end

  assign wr_events    = we && (address == BASE_ADDR + OFF_EVENTS);
  assign wr_irq_en    = we && (address == BASE_ADDR + OFF_IRQ_EN);
  assign unused_wdata = ^wdata[31:NUM_EVENTS];

  always_comb begin
    ev_set                        = '0;
    ev_set[EV_BTN0 +: NUM_BTN]    = stable[NUM_BTN-1:0] & ~stable_q[NUM_BTN-1:0];
    ev_set[EV_SW]                 = |(stable[NUM_IN-1:NUM_BTN] ^ stable_q[NUM_IN-1:NUM_BTN]);
    ev_clr                        = wr_events ? wdata[NUM_EVENTS-1:0] : '0;
  end

  always_comb begin
    rdata = '0;
    case (address)
      BASE_ADDR + OFF_SWITCHES: rdata = 32'(stable[NUM_IN-1:NUM_BTN]);
      BASE_ADDR + OFF_BUTTONS:  rdata = 32'(stable[NUM_BTN-1:0]);
      BASE_ADDR + OFF_EVENTS:   rdata = 32'(events);
      BASE_ADDR + OFF_IRQ_EN:   rdata = 32'(irq_en);
      default:                  rdata = '0;
    endcase
  end

  // Set is OR-ed after the clear so a simultaneous event survives the W1C
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= '0;
      events   <= '0;
      irq_en   <= '0;
      irq      <= 1'b0;
      data_out <= '0;
    end else begin
      stable_q <= stable;
      events   <= (events & ~ev_clr) | ev_set;
      if (wr_irq_en) begin
        irq_en <= wdata[NUM_EVENTS-1:0];
      end
      irq      <= |(events & irq_en);
      data_out <= rdata;
    end
  end

endmodule

// File: tb/tb_input_event_ctrl.sv
// Bench for input_event_ctrl: directed scenarios plus random pin/bus traffic
// checked every cycle against a behavioural model of the register block.
module tb_input_event_ctrl;
  import input_event_pkg::*;

  localparam int unsigned D    = 4;
  localparam logic [31:0] BASE = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic        we;
  logic [31:0] wdata;
  logic [15:0] switches;
  logic [3:0]  buttons;
  logic [31:0] data_out;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  input_event_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .BASE_ADDR      (BASE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .address (address),
    .we      (we),
    .wdata   (wdata),
    .switches(switches),
    .buttons (buttons),
    .data_out(data_out),
    .irq     (irq)
  );

  // Reference model: pins reach the filter two samples late; a level is
  // accepted once it has disagreed with the accepted level D samples in a row.
  logic [19:0] m_p1, m_p2, m_level, m_level_d;
  int          m_run [20];
  logic [4:0]  m_ev, m_en;
  logic [31:0] m_dout;
  logic        m_irq;

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [19:0] lv,
                                             input logic [4:0] ev, input logic [4:0] en);
    if (a == BASE)      return {16'h0, lv[19:4]};
    if (a == BASE + 4)  return {28'h0, lv[3:0]};
    if (a == BASE + 8)  return {27'h0, ev};
    if (a == BASE + 12) return {27'h0, en};
    return 32'h0;
  endfunction

  always @(posedge clk) begin : model
    logic [19:0] lv_old, lvd_old;
    logic [4:0]  ev_old, set, clr;
    if (rst) begin
      m_p1 = '0; m_p2 = '0; m_level = '0; m_level_d = '0;
      m_ev = '0; m_en = '0; m_dout = '0; m_irq = 1'b0;
      for (int i = 0; i < 20; i++) m_run[i] = 0;
    end else begin
      lv_old  = m_level;
      lvd_old = m_level_d;
      ev_old  = m_ev;
      m_dout  = model_read(address, lv_old, ev_old, m_en);
      m_irq   = |(ev_old & m_en);
      for (int i = 0; i < 20; i++) begin
        if (m_p2[i] != m_level[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == D) begin
            m_level[i] = m_p2[i];
            m_run[i]   = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_p2      = m_p1;
      m_p1      = {switches, buttons};
      m_level_d = lv_old;
      set = {(lv_old[19:4] != lvd_old[19:4]), lv_old[3:0] & ~lvd_old[3:0]};
      clr = (we && address == BASE + 8) ? wdata[4:0] : 5'h0;
      m_ev = (ev_old & ~clr) | set;
      if (we && address == BASE + 12) m_en = wdata[4:0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_dout"}, data_out, m_dout);
    chk({tag, "_irq"}, {31'h0, irq}, {31'h0, m_irq});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    address = a; wdata = d; we = 1'b1;
    step("wr");
    we = 1'b0;
  endtask

  logic [31:0] addrs [6];
  int          idx;

  initial begin
    addrs = '{BASE, BASE + 4, BASE + 8, BASE + 12, BASE + 16, BASE - 4};
    rst = 1'b1; address = BASE; we = 1'b0; wdata = '0; switches = '0; buttons = '0;
    step("rst");
    step("rst");
    chk("rst_dout0", data_out, 32'h0);
    chk("rst_irq0", {31'h0, irq}, 32'h0);
    rst = 1'b0;

    // Button 0 press with its interrupt enabled
    wr(BASE + 12, 32'h1);
    buttons = 4'h1; address = BASE + 4;
    for (int c = 1; c <= 8; c++) begin
      step("btn0");
      chk("btn0_level", data_out, (c >= 7) ? 32'h1 : 32'h0);
      chk("btn0_irq", {31'h0, irq}, (c >= 8) ? 32'h1 : 32'h0);
    end
    address = BASE + 8;
    step("btn0_ev");
    chk("btn0_events", data_out, 32'h1);

    // Clear, then a 3-cycle glitch on button 2 must be filtered
    wr(BASE + 8, 32'h1F);
    buttons = 4'h5;
    repeat (3) step("glitch");
    buttons = 4'h1;
    repeat (10) step("glitch");
    chk("glitch_events", data_out, 32'h0);
    chk("glitch_irq", {31'h0, irq}, 32'h0);
    address = BASE + 4;
    step("glitch");
    chk("glitch_level", data_out, 32'h1);

    // Release button 0, clear, then set/clear collision on bit 0
    buttons = 4'h0;
    repeat (8) step("rel");
    wr(BASE + 8, 32'h1F);
    buttons = 4'h1;
    repeat (6) step("coll");
    wr(BASE + 8, 32'h1);
    address = BASE + 8;
    step("coll");
    chk("coll_set_wins", data_out, 32'h1);

    // Switch pattern, change event and its clear
    switches = 16'hA5A5; address = BASE;
    repeat (8) step("sw");
    chk("sw_level", data_out, 32'h0000_A5A5);
    address = BASE + 8;
    step("sw");
    chk("sw_event", data_out & 32'h10, 32'h10);
    wr(BASE + 8, 32'h11);
    address = BASE + 8;
    step("sw");
    chk("sw_cleared", data_out, 32'h0);

    // IRQ_EN width, unmapped reads, writes to read-only space
    wr(BASE + 12, 32'hFFFF_FFFF);
    address = BASE + 12;
    step("en");
    chk("en_mask", data_out, 32'h1F);
    address = BASE + 16;
    step("unm");
    chk("unmapped_hi", data_out, 32'h0);
    address = BASE - 4;
    step("unm");
    chk("unmapped_lo", data_out, 32'h0);
    wr(BASE, 32'h0);
    address = BASE;
    step("ro");
    chk("ro_switches", data_out, 32'h0000_A5A5);

    // Reset in the middle of a debounce count
    buttons = 4'h0;
    repeat (8) step("pre");
    wr(BASE + 8, 32'h1F);
    buttons = 4'h1;
    repeat (4) step("mid");
    rst = 1'b1; address = BASE + 8;
    step("mid_rst");
    chk("midrst_dout", data_out, 32'h0);
    chk("midrst_irq", {31'h0, irq}, 32'h0);
    rst = 1'b0; address = BASE + 12;
    step("post");
    chk("post_events", data_out, 32'h0);
    address = BASE + 4;
    step("post");
    chk("post_en", data_out, 32'h0);
    for (int c = 3; c <= 7; c++) begin
      step("post");
      chk("post_level", data_out, (c >= 7) ? 32'h1 : 32'h0);
    end

    // Random pin activity and bus traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        idx = int'($urandom_range(0, 19));
        if (idx < 4) buttons[idx] = ~buttons[idx];
        else         switches[idx - 4] = ~switches[idx - 4];
      end
      address = addrs[$urandom_range(0, 5)];
      we      = ($urandom_range(0, 7) == 0);
      wdata   = $urandom;
      step("rand");
    end
    we = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_event_ctrl.md
# input_event_ctrl

Memory-mapped controller for the board's slide switches and push buttons, sitting on the processor data bus at base 0x0000_2000. It synchronizes and debounces all 20 raw inputs and latches button presses and switch changes into sticky, write-1-to-clear event flags. It raises a level interrupt for enabled events and serves the level, event and enable registers through a registered read port.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable synchronized cycles before a level is accepted (10 ms at 100 MHz); must be ≥ 1.
- BASE_ADDR, 32'h0000_2000: register block base.
- clk  in  1  system clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- address  in  32  byte address from the core.
- we  in  1  write strobe, single cycle.
- wdata  in  32  write data.
- switches  in  16  raw, asynchronous slide-switch pins.
- buttons  in  4  raw, asynchronous push-button pins, active-high.
- data_out  out  32  registered read data.
- irq  out  1  level interrupt: |(EVENTS & IRQ_EN).

## Operation
- Register map, word offsets from BASE_ADDR:
  - 0x0 SWITCHES (RO): bits[15:0] debounced switches; upper bits 0.
  - 0x4 BUTTONS (RO): bits[3:0] debounced buttons.
  - 0x8 EVENTS (RW1C):
    - bits[3:0] set on each debounced button rising edge.
    - bit 4 set on any debounced switch change.
    - writing 1 clears a bit; writing 0 has no effect.
  - 0xC IRQ_EN (RW): bits[4:0]; all other bits read 0 and ignore writes.
- Any other address reads 0. Writes to RO or unmapped addresses are ignored.
- Per input bit:
  - Two-flop synchronizer.
  - Counter clears whenever the synchronized value equals the stable value. Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the stable value takes the synchronized value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches the stable value.
- Counter width: $clog2(DEBOUNCE_CYCLES). Saturation is impossible by construction.
- Edge detect compares the stable value with its value one cycle earlier.
- If an event set and a W1C clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- data_out updates every cycle from the address sampled that cycle. There is no read strobe; reads have no side effects.

## Timing
- Reset values:
  - data_out = 0, irq = 0.
  - Synchronizers, stable values, edge history and counters = 0.
  - EVENTS = 0, IRQ_EN = 0.
- Pin to stable level: a raw change held steady shows in the stable value 2 + DEBOUNCE_CYCLES cycles after the first clk edge that samples it.
- Stable level to event: the EVENTS bit is 1 at the next edge. irq asserts at the edge after that.
- Read latency: data_out reflects the register at the address presented on the cycle before.
- Write: takes effect at the edge where we=1. A read of the same register in the next cycle returns the new value.
- Reset asserted mid-debounce discards partial counts. An input already high at release must be held for the full debounce time again.
- Reset held at startup with buttons already pressed:
  - Produces a rising-edge event after debounce, because the stable value resets to 0.
  - Software clears it once at boot.

## Structure
- Package input_event_pkg:
  - Offsets OFF_SWITCHES, OFF_BUTTONS, OFF_EVENTS, OFF_IRQ_EN.
  - Event bit indices EV_BTN0..EV_BTN3 and EV_SW.
  - NUM_EVENTS = 5.
- Sub-module debounce_bit:
  - Parameter DEBOUNCE_CYCLES; ports clk, rst, raw, stable.
  - Contains the synchronizer and counter.
  - Instantiated 20 times by generate.
- The top holds edge detect, event/enable registers, address decode and the read mux.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Button 0 raised and held → BUTTONS=0x1 at cycle 6. EVENTS=0x01 at cycle 7. With IRQ_EN=0x01, irq=1 from cycle 8.
- Button 2 pulses for 3 cycles, then low → BUTTONS stays 0, EVENTS stays 0, irq stays 0.
- Switches set to 0xA5A5 and held → read 0x2000 returns 0x0000_A5A5. EVENTS bit 4 = 1. Write 0x10 to 0x2008 → EVENTS reads 0.
- Write 0x1 to 0x2008 in the same cycle button 0's event sets → EVENTS bit 0 remains 1.
- Write 0xFFFF_FFFF to 0x200C → reads 0x1F. Reads of 0x2010 and 0x1FFC return 0. A write to 0x2000 leaves SWITCHES unchanged.
- Reset asserted for 1 cycle mid-debounce (counter at 2) → all registers 0. Button still high → BUTTONS=1 six cycles after reset release.
